mont_result_unloader: RTL and testbench

//  Downstream stage of the Montgomery multiplier. Captures the 1024-bit product when the

---
 rtl/mont_result_unloader.sv | 156 +++++++++++++++
 tb/tb_mont_result_unloader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_result_unloader.sv
// Output stage of the Montgomery multiplier: captures the product, range-checks it
// against the modulus MSW-first, then streams it out LSW-first over valid/ready.
module mont_result_unloader #(
    parameter int unsigned SIZE_INPUT = 1024,
    parameter int unsigned WORD_SIZE  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SIZE_INPUT-1:0] i_result_in,
    input  logic                  i_result_done,
    input  logic [SIZE_INPUT-1:0] i_mod_n,
    output logic [WORD_SIZE-1:0]  o_out_word,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_out_last,
    output logic                  o_range_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int unsigned WORDS = SIZE_INPUT / WORD_SIZE;
    localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StStream
    } state_e;

    state_e                r_state, w_state_d;
    logic [SIZE_INPUT-1:0] r_buf, w_buf_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic [CW-1:0]         r_idx, w_idx_d;
    logic                  r_done_q;
    logic [WORD_SIZE-1:0]  r_word, w_word_d;
    logic                  r_valid, w_valid_d;
    logic                  r_last, w_last_d;
    logic                  r_range_err, w_range_err_d;
    logic                  r_overrun, w_overrun_d;
    logic                  r_busy, w_busy_d;

    logic                  w_rise;
    logic                  w_to_stream;
    logic [CW-1:0]         w_idx_nxt;
    logic [WORD_SIZE-1:0]  w_buf_word;
    logic [WORD_SIZE-1:0]  w_mod_word;

    assign w_rise     = i_result_done && !r_done_q;
    assign w_idx_nxt  = r_idx + CW'(1);
    assign w_buf_word = r_buf[r_cnt*WORD_SIZE +: WORD_SIZE];
    assign w_mod_word = i_mod_n[r_cnt*WORD_SIZE +: WORD_SIZE];

    always_comb begin
        w_state_d     = r_state;
        w_buf_d       = r_buf;
        w_cnt_d       = r_cnt;
        w_idx_d       = r_idx;
        w_word_d      = r_word;
        w_valid_d     = r_valid;
        w_last_d      = r_last;
        w_range_err_d = r_range_err;
        w_overrun_d   = r_overrun;
        w_busy_d      = r_busy;
        w_to_stream   = 1'b0;

        if (w_rise && (r_state != StIdle)) begin
            w_overrun_d = 1'b1;
        end

        case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_buf_d       = i_result_in;
                    w_cnt_d       = LastIdx;
                    w_range_err_d = 1'b0;
                    w_busy_d      = 1'b1;
                    w_state_d     = StCheck;
                end
            end
            StCheck: begin
                // Equality at the last word means result == N, which is out of range.
                if (w_buf_word > w_mod_word) begin
                    w_range_err_d = 1'b1;
                    w_to_stream   = 1'b1;
                end else if (w_buf_word < w_mod_word) begin
                    w_to_stream   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_range_err_d = 1'b1;
                    w_to_stream   = 1'b1;
                end else begin
                    w_cnt_d       = r_cnt - CW'(1);
                end
            end
            StStream: begin
                if (r_valid && i_out_ready) begin
                    if (r_idx == LastIdx) begin
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        w_busy_d  = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_idx_d  = w_idx_nxt;
                        w_word_d = r_buf[w_idx_nxt*WORD_SIZE +: WORD_SIZE];
                        w_last_d = (w_idx_nxt == LastIdx);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_to_stream) begin
            w_state_d = StStream;
            w_idx_d   = '0;
            w_valid_d = 1'b1;
            w_word_d  = r_buf[0 +: WORD_SIZE];
            w_last_d  = (WORDS == 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_done_q    <= 1'b0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_range_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_buf       <= w_buf_d;
            r_cnt       <= w_cnt_d;
            r_idx       <= w_idx_d;
            r_done_q    <= i_result_done;
            r_word      <= w_word_d;
            r_valid     <= w_valid_d;
            r_last      <= w_last_d;
            r_range_err <= w_range_err_d;
            r_overrun   <= w_overrun_d;
            r_busy      <= w_busy_d;
        end
    end

    assign o_out_word  = r_word;
    assign o_out_valid = r_valid;
    assign o_out_last  = r_last;
    assign o_range_err = r_range_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mont_result_unloader.sv
// Scoreboard bench for mont_result_unloader: expected words are queued at capture
// and compared as each word is accepted on the output handshake.
module tb_mont_result_unloader;

    localparam int S = 1024;
    localparam int W = 64;
    localparam int N = S / W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [S-1:0] i_result_in = '0;
    logic         i_result_done = 1'b0;
    logic [S-1:0] i_mod_n = '0;
    logic [W-1:0] o_out_word;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic         o_out_last;
    logic         o_range_err;
    logic         o_overrun;
    logic         o_busy;

    typedef struct packed {
        logic [W-1:0] w;
        logic         l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc = 0;

    mont_result_unloader #(
        .SIZE_INPUT(S),
        .WORD_SIZE (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_result_in  (i_result_in),
        .i_result_done(i_result_done),
        .i_mod_n      (i_mod_n),
        .o_out_word   (o_out_word),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_last   (o_out_last),
        .o_range_err  (o_range_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [S-1:0] seq_words();
        logic [S-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 64'(i + 1);
        return v;
    endfunction

    task automatic push_words(input logic [S-1:0] v);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.w = v[i*W +: W];
            e.l = (i == N - 1);
            sb.push_back(e);
        end
    endtask

    // Output monitor: sample at the falling edge, away from the active edge.
    initial begin
        logic         stall;
        logic [W-1:0] prev_word;
        logic         prev_last;
        exp_t         e;
        stall = 1'b0;
        prev_word = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && o_out_valid) begin
                if (stall) begin
                    check("hold_word", 64'(o_out_word), 64'(prev_word));
                    check("hold_last", 64'(o_out_last), 64'(prev_last));
                end
                if (i_out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("word", 64'(o_out_word), 64'(e.w));
                        check("last", 64'(o_out_last), 64'(e.l));
                    end
                    n_acc++;
                end
                stall = !i_out_ready;
                prev_word = o_out_word;
                prev_last = o_out_last;
            end else begin
                stall = 1'b0;
            end
        end
    end

    // ready_mode 0: ready held high; 1: ready alternates 1,0 starting with 1.
    task automatic run_txn(input logic [S-1:0] res, input logic [S-1:0] mn, input int exp_k,
                           input logic exp_err, input int ready_mode, input bit hold_done,
                           input bit raise_at5, input logic exp_ovr);
        int edges;
        int cycles;
        int base;
        i_result_in = res;
        i_mod_n = mn;
        i_out_ready = 1'b0;
        push_words(res);
        base = n_acc;
        i_result_done = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        check("busy_set", 64'(o_busy), 64'(1));
        check("err_clear", 64'(o_range_err), 64'(0));
        if (!hold_done) i_result_done = 1'b0;
        while (!o_out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(exp_k + 1));
        cycles = 0;
        while (o_busy && cycles < 100) begin
            i_out_ready = (ready_mode == 0) ? 1'b1 : ((cycles % 2) == 0);
            if (raise_at5 && (n_acc - base) == 5) i_result_done = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        i_out_ready = 1'b0;
        check("cycles", 64'(cycles), 64'((ready_mode == 0) ? N : 2 * N - 1));
        check("words", 64'(n_acc - base), 64'(N));
        check("valid_end", 64'(o_out_valid), 64'(0));
        check("range_err", 64'(o_range_err), 64'(exp_err));
        check("overrun", 64'(o_overrun), 64'(exp_ovr));
        check("sb_left", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, 64'(o_out_word), 64'(0));
        check({tag, "_valid"}, 64'(o_out_valid), 64'(0));
        check({tag, "_last"}, 64'(o_out_last), 64'(0));
        check({tag, "_err"}, 64'(o_range_err), 64'(0));
        check({tag, "_ovr"}, 64'(o_overrun), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [S-1:0] seq;
        logic [S-1:0] ones;
        logic [S-1:0] v;
        logic [S-1:0] m;
        int c;
        seq = seq_words();
        ones = {S{1'b1}};

        #2 reset = 1'b1;
        #2 check_all_zero("reset_init");
        @(posedge clk); #1 reset = 1'b0;

        // Reset in the middle of a stream.
        i_result_in = seq;
        i_mod_n = ones;
        push_words(seq);
        i_result_done = 1'b1;
        @(posedge clk); #1;
        i_result_done = 1'b0;
        i_out_ready = 1'b1;
        c = 0;
        while (n_acc < 4 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("mid_words", 64'(n_acc), 64'(4));
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid");
        sb.delete();
        @(posedge clk); #1 reset = 1'b0;
        c = n_acc;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_valid", 64'(o_out_valid), 64'(0));
        check("post_reset_words", 64'(n_acc), 64'(c));
        i_out_ready = 1'b0;

        run_txn(seq, ones, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_txn(seq, ones, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        run_txn(seq, seq, N, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        // Back-to-back: word 0 below the modulus only at the last checked word.
        m = seq;
        m[0 +: W] = 64'h2;
        run_txn(seq, m, N, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        m = seq;
        m[S-1 -: W] = '0;
        run_txn(seq, m, 1, 1'b1, 1, 1'b0, 1'b0, 1'b0);

        v = seq ^ {S/2{2'b10}};
        run_txn(v, ones, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("no_recapture", 64'(o_busy), 64'(0));
        check("hold_overrun", 64'(o_overrun), 64'(0));
        i_result_done = 1'b0;
        @(posedge clk); #1;

        run_txn(seq, ones, 1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        i_result_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("overrun_sticky", 64'(o_overrun), 64'(1));
        check("overrun_idle", 64'(o_busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
